// File: rtl/mo_line_buffer_if.sv
// -----------------------------------------------------------------------------
// mo_line_buffer_if
// Bundle of the line-buffer control, write and read signals between the
// motion-object shifter / priority control (master) and mo_line_buffer (slave).
//
// Signals:
//   line_swap  end-of-line pulse, exchanges write/read banks
//   wr_load    load write X counter from wr_x
//   wr_x       start X for next object slice
//   wr_en      wr_pix valid this cycle
//   wr_pix     object pixel
//   rd_en      advance readout one pixel
//   rd_pix     registered readout pixel
//   rd_valid   rd_pix holds an in-range pixel
//   wr_bank    bank currently being written (read bank is ~wr_bank)
//   wr_ovf     sticky non-transparent write dropped past end of line
//
// Handshake: wr_en and rd_en are valid-only strobes. The buffer is always
// ready, so every cycle with wr_en high consumes wr_pix and every cycle with
// rd_en high produces a pixel one cycle later; there is no backpressure.
// -----------------------------------------------------------------------------
interface mo_line_buffer_if #(
   parameter int PIX_W = 8,
   parameter int XW    = 9
);
   logic             line_swap;
   logic             wr_load;
   logic [XW-1:0]    wr_x;
   logic             wr_en;
   logic [PIX_W-1:0] wr_pix;
   logic             rd_en;
   logic [PIX_W-1:0] rd_pix;
   logic             rd_valid;
   logic             wr_bank;
   logic             wr_ovf;

   modport master (
      output line_swap, wr_load, wr_x, wr_en, wr_pix, rd_en,
      input  rd_pix, rd_valid, wr_bank, wr_ovf
   );

   modport slave (
      input  line_swap, wr_load, wr_x, wr_en, wr_pix, rd_en,
      output rd_pix, rd_valid, wr_bank, wr_ovf
   );
endinterface

// File: rtl/mo_line_buffer.sv
// -----------------------------------------------------------------------------
// mo_line_buffer
// Ping-pong motion-object horizontal line buffer. One bank is written by the
// object shifter while the other is read out (and cleared behind the read)
// towards priority control; line_swap exchanges them.
//
// Ports:
//   clk   pixel clock, all logic on the rising edge
//   rst   synchronous active-high reset (clears both banks to transparent)
//   bus   mo_line_buffer_if.slave: line_swap, wr_load/wr_x, wr_en/wr_pix,
//         rd_en, rd_pix/rd_valid, wr_bank, wr_ovf
//
// Optional feature: define MOLB_PRIORITY_EN to make opaque writes only
// replace an entry that is transparent or has priority <= the new pixel.
// Without it the last opaque write to an X always wins.
// -----------------------------------------------------------------------------
module mo_line_buffer #(
   parameter int PIX_W    = 8,
   parameter int XW       = 9,
   parameter int LINE_LEN = 336,
   parameter int TRANS_W  = 4,
   parameter int PRI_W    = 2
) (
   input  logic               clk,
   input  logic               rst,
   mo_line_buffer_if.slave    bus
);
   localparam logic [PIX_W-1:0] CLR_VAL = '1;
   // One extra bit so the read counter can sit at LINE_LEN == 2^XW.
   localparam logic [XW:0]      LEN_C   = (XW+1)'(LINE_LEN);

   if (PRI_W > PIX_W - TRANS_W || LINE_LEN > (1 << XW)) begin : g_param_check
      $error("mo_line_buffer: inconsistent PRI_W/TRANS_W/LINE_LEN parameters");
   end

   logic [PIX_W-1:0] r_mem [2][LINE_LEN];
   logic             r_wr_bank;
   logic [XW-1:0]    r_wx;
   logic [XW:0]      r_rx;
   logic [PIX_W-1:0] r_rd_pix;
   logic             r_rd_valid;
   logic             r_wr_ovf;

   logic [XW-1:0]    w_wx_eff;
   logic             w_opaque;
   logic             w_wx_ok;
   logic             w_rx_ok;
   logic             w_rd_bank;
   logic             w_win;

   always_comb begin
      // A load in the same cycle as a write places that pixel at wr_x.
      w_wx_eff  = bus.wr_load ? bus.wr_x : r_wx;
      w_opaque  = ~&bus.wr_pix[TRANS_W-1:0];
      w_wx_ok   = {1'b0, w_wx_eff} < LEN_C;
      w_rx_ok   = r_rx < LEN_C;
      w_rd_bank = ~r_wr_bank;
   end

`ifdef MOLB_PRIORITY_EN
   logic [PIX_W-1:0] w_old;
   assign w_old = r_mem[r_wr_bank][w_wx_eff];
   // Ties go to the newer pixel; a transparent entry is always replaceable.
   assign w_win = (&w_old[TRANS_W-1:0]) ||
                  (bus.wr_pix[PIX_W-1 -: PRI_W] >= w_old[PIX_W-1 -: PRI_W]);
`else
   assign w_win = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < LINE_LEN; i++) begin
               r_mem[b][i] <= CLR_VAL;
            end
         end
         r_wr_bank  <= 1'b0;
         r_wx       <= '0;
         r_rx       <= '0;
         r_rd_pix   <= CLR_VAL;
         r_rd_valid <= 1'b0;
         r_wr_ovf   <= 1'b0;
      end else begin
         // Write side: transparent pixels never store but still advance X.
         if (bus.wr_en && w_opaque) begin
            if (w_wx_ok) begin
               if (w_win) begin
                  r_mem[r_wr_bank][w_wx_eff] <= bus.wr_pix;
               end
            end else begin
               r_wr_ovf <= 1'b1;
            end
         end
         if (bus.wr_en) begin
            r_wx <= w_wx_eff + 1'b1;
         end else if (bus.wr_load) begin
            r_wx <= bus.wr_x;
         end

         // Read side: clear-behind leaves the bank transparent for reuse.
         if (bus.rd_en) begin
            if (w_rx_ok) begin
               r_rd_pix                      <= r_mem[w_rd_bank][r_rx[XW-1:0]];
               r_mem[w_rd_bank][r_rx[XW-1:0]] <= CLR_VAL;
               r_rd_valid                    <= 1'b1;
               r_rx                          <= r_rx + 1'b1;
            end else begin
               r_rd_pix   <= CLR_VAL;
               r_rd_valid <= 1'b0;
            end
         end else begin
            r_rd_valid <= 1'b0;
         end

         // Swap comes last so it overrides counter updates of the same cycle;
         // the memory accesses above still hit the old banks.
         if (bus.line_swap) begin
            r_wr_bank <= ~r_wr_bank;
            r_rx      <= '0;
            r_wx      <= '0;
            r_wr_ovf  <= 1'b0;
         end
      end
   end

   assign bus.rd_pix   = r_rd_pix;
   assign bus.rd_valid = r_rd_valid;
   assign bus.wr_bank  = r_wr_bank;
   assign bus.wr_ovf   = r_wr_ovf;

endmodule
